// File: rtl/y86_fde_core_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg: shared constants for the Y86-64 fetch/decode/execute slice.
//   - instruction codes (icode), ALU function codes, branch/move conditions
//   - register identifiers for %rsp and "no register"
//   - status codes (INS is encoded as 0 because stat is only two bits wide)
//   - helpers giving the natural length and register-byte presence per icode
// -----------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD  = 4'h0;
  localparam logic [3:0] ALUSUB  = 4'h1;
  localparam logic [3:0] ALUAND  = 4'h2;
  localparam logic [3:0] ALUXOR  = 4'h3;

  localparam logic [3:0] C_YES   = 4'h0;
  localparam logic [3:0] C_LE    = 4'h1;
  localparam logic [3:0] C_L     = 4'h2;
  localparam logic [3:0] C_E     = 4'h3;
  localparam logic [3:0] C_NE    = 4'h4;
  localparam logic [3:0] C_GE    = 4'h5;
  localparam logic [3:0] C_G     = 4'h6;

  localparam logic [3:0] RRSP    = 4'h4;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [1:0] STAT_INS = 2'd0;
  localparam logic [1:0] STAT_AOK = 2'd1;
  localparam logic [1:0] STAT_HLT = 2'd2;
  localparam logic [1:0] STAT_ADR = 2'd3;

  // Encoded length of a legal instruction with the given icode.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: instr_len = 4'd2;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:    instr_len = 4'd10;
      IJXX, ICALL:                  instr_len = 4'd9;
      default:                      instr_len = 4'd1;
    endcase
  endfunction

  // Whether byte 1 of the instruction carries rA/rB.
  function automatic logic has_regids(input logic [3:0] code);
    case (code)
      IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: has_regids = 1'b1;
      default:                                                 has_regids = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_fde_core_alu.sv
// -----------------------------------------------------------------------------
// y86_alu: 64-bit ALU computing res = b op a with Y86 flag generation.
//   a_i   : first operand (valA / constant side)
//   b_i   : second operand (valB side); subtraction is b_i - a_i
//   fun_i : ALUADD / ALUSUB / ALUAND / ALUXOR, anything else yields 0
//   res_o : 64-bit wrap-around result
//   zf_o, sf_o, of_o : zero, sign and signed-overflow flags of res_o
// -----------------------------------------------------------------------------
module y86_alu
  import y86_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [3:0]  fun_i,
  output logic [63:0] res_o,
  output logic        zf_o,
  output logic        sf_o,
  output logic        of_o
);

  logic [63:0] res;
  logic        ovf;

  // Result and overflow selection by function code.
  always_comb begin
    res = 64'd0;
    ovf = 1'b0;
    case (fun_i)
      ALUADD: begin
        res = b_i + a_i;
        ovf = (a_i[63] == b_i[63]) && (res[63] != b_i[63]);
      end
      ALUSUB: begin
        res = b_i - a_i;
        ovf = (a_i[63] != b_i[63]) && (res[63] != b_i[63]);
      end
      ALUAND:  res = b_i & a_i;
      ALUXOR:  res = b_i ^ a_i;
      default: res = 64'd0;
    endcase
  end

  assign res_o = res;
  assign zf_o  = (res == 64'd0);
  assign sf_o  = res[63];
  assign of_o  = ovf;

endmodule

// File: rtl/y86_fde_core.sv
// -----------------------------------------------------------------------------
// y86_fde_core: fetch, decode/writeback and execute of a SEQ Y86-64 CPU.
//   Inputs : clk, rst_n (async, active low), pc, inst (10-byte window at pc,
//            little-endian), valM (data memory read value for writeback)
//   Fetch  : icode, ifun, rA, rB, valC, valP, instr_valid, imem_error, halt
//   Decode : valA, valB from the 15-entry register file
//   Execute: valE, cnd, condition codes zf/sf/of
//   Status : stat (1 AOK, 2 HLT, 3 ADR, 0 INS)
//   State  : regs_flat exposes register i at [64i+63:64i]
// Registers and condition codes update at the rising edge only when stat is
// AOK. The PC register, data memory and next-PC selection live elsewhere.
// -----------------------------------------------------------------------------
module y86_fde_core
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  pc,
  input  logic [79:0]  inst,
  input  logic [63:0]  valM,
  output logic [3:0]   icode,
  output logic [3:0]   ifun,
  output logic [3:0]   rA,
  output logic [3:0]   rB,
  output logic [63:0]  valC,
  output logic [63:0]  valP,
  output logic [63:0]  valA,
  output logic [63:0]  valB,
  output logic [63:0]  valE,
  output logic         cnd,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         instr_valid,
  output logic         imem_error,
  output logic         halt,
  output logic [1:0]   stat,
  output logic [959:0] regs_flat
);

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];
  logic        zf_q, sf_q, of_q;
  logic        zf_d, sf_d, of_d;

  logic [3:0]  len;
  logic [64:0] end_addr;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic        alu_zf, alu_sf, alu_of;
  logic        aok, we_e, we_m, cc_en;

  // ---------------------------------------------------------------- fetch
  assign icode = inst[7:4];
  assign ifun  = inst[3:0];

  // Legal ifun range depends on the icode; icodes above B are never legal.
  always_comb begin
    instr_valid = 1'b0;
    case (icode)
      IRRMOVQ, IJXX: instr_valid = (ifun <= C_G);
      IOPQ:          instr_valid = (ifun <= ALUXOR);
      IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ:
                     instr_valid = (ifun == 4'h0);
      default:       instr_valid = 1'b0;
    endcase
  end

  // An illegal instruction is treated as one byte long.
  assign len = instr_valid ? instr_len(icode) : 4'd1;
  assign rA  = has_regids(icode) ? inst[15:12] : RNONE;
  assign rB  = has_regids(icode) ? inst[11:8]  : RNONE;

  // Constant field position depends on whether a register byte precedes it.
  always_comb begin
    valC = 64'd0;
    case (icode)
      IIRMOVQ, IRMMOVQ, IMRMOVQ: valC = inst[79:16];
      IJXX, ICALL:               valC = inst[71:8];
      default:                   valC = 64'd0;
    endcase
  end

  assign valP = pc + {60'd0, len};
  // One extra bit so a pc near 2^64 cannot wrap past the memory bound.
  assign end_addr   = {1'b0, pc} + {61'd0, len};
  assign imem_error = (end_addr > 65'(IMEM_SIZE));
  assign halt       = (icode == IHALT);

  // Status priority: address error, then illegal instruction, then halt.
  always_comb begin
    if (imem_error) begin
      stat = STAT_ADR;
    end else if (!instr_valid) begin
      stat = STAT_INS;
    end else if (halt) begin
      stat = STAT_HLT;
    end else begin
      stat = STAT_AOK;
    end
  end

  assign aok = (stat == STAT_AOK);

  // --------------------------------------------------------------- decode
  // Source register selection for the two read ports.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (icode)
      IRRMOVQ, IOPQ:   begin src_a = rA;    src_b = (icode == IOPQ) ? rB : RNONE; end
      IRMMOVQ:         begin src_a = rA;    src_b = rB;    end
      IMRMOVQ:         begin src_a = RNONE; src_b = rB;    end
      IPUSHQ:          begin src_a = rA;    src_b = RRSP;  end
      IRET, IPOPQ:     begin src_a = RRSP;  src_b = RRSP;  end
      ICALL:           begin src_a = RNONE; src_b = RRSP;  end
      default:         begin src_a = RNONE; src_b = RNONE; end
    endcase
  end

  assign valA = (src_a == RNONE) ? 64'd0 : regs_q[src_a];
  assign valB = (src_b == RNONE) ? 64'd0 : regs_q[src_b];

  // -------------------------------------------------------------- execute
  // ALU operand/function routing; moves pass through as a + 0.
  always_comb begin
    alu_a   = 64'd0;
    alu_b   = 64'd0;
    alu_fun = ALUADD;
    case (icode)
      IRRMOVQ:          begin alu_a = valA;  alu_b = 64'd0; end
      IIRMOVQ:          begin alu_a = valC;  alu_b = 64'd0; end
      IRMMOVQ, IMRMOVQ: begin alu_a = valC;  alu_b = valB;  end
      IOPQ:             begin alu_a = valA;  alu_b = valB;  alu_fun = ifun; end
      ICALL, IPUSHQ:    begin alu_a = 64'd8; alu_b = valB;  alu_fun = ALUSUB; end
      IRET, IPOPQ:      begin alu_a = 64'd8; alu_b = valB;  end
      default:          begin alu_a = 64'd0; alu_b = 64'd0; end
    endcase
  end

  y86_alu u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .fun_i (alu_fun),
    .res_o (valE),
    .zf_o  (alu_zf),
    .sf_o  (alu_sf),
    .of_o  (alu_of)
  );

  // Branch / conditional-move condition from the stored flags.
  always_comb begin
    cnd = 1'b0;
    if (icode == IRRMOVQ || icode == IJXX) begin
      case (ifun)
        C_YES:   cnd = 1'b1;
        C_LE:    cnd = (sf_q ^ of_q) | zf_q;
        C_L:     cnd = sf_q ^ of_q;
        C_E:     cnd = zf_q;
        C_NE:    cnd = ~zf_q;
        C_GE:    cnd = ~(sf_q ^ of_q);
        C_G:     cnd = ~(sf_q ^ of_q) & ~zf_q;
        default: cnd = 1'b0;
      endcase
    end else begin
      cnd = 1'b0;
    end
  end

  // ------------------------------------------------------------ writeback
  // Destination selection; a failed cmov targets no register.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IRRMOVQ:                    dst_e = cnd ? rB : RNONE;
      IIRMOVQ, IOPQ:              dst_e = rB;
      ICALL, IRET, IPUSHQ:        dst_e = RRSP;
      IPOPQ:                begin dst_e = RRSP; dst_m = rA; end
      IMRMOVQ:                    dst_m = rA;
      default:              begin dst_e = RNONE; dst_m = RNONE; end
    endcase
  end

  assign we_e  = aok && (dst_e != RNONE);
  assign we_m  = aok && (dst_m != RNONE);
  assign cc_en = aok && instr_valid && (icode == IOPQ);

  // Next register file contents; the memory port takes priority so that
  // popq %rsp leaves the popped value in %rsp.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      if (we_m && (dst_m == 4'(i))) begin
        regs_d[i] = valM;
      end else if (we_e && (dst_e == 4'(i))) begin
        regs_d[i] = valE;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  assign zf_d = cc_en ? alu_zf : zf_q;
  assign sf_d = cc_en ? alu_sf : sf_q;
  assign of_d = cc_en ? alu_of : of_q;

  // Register file and condition-code state; reset leaves ZF set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= 64'd0;
      end
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= regs_d[i];
      end
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;

  // Flattened view of the register file.
  always_comb begin
    regs_flat = 960'd0;
    for (int i = 0; i < 15; i++) begin
      regs_flat[64*i +: 64] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_y86_fde_core.sv
// -----------------------------------------------------------------------------
// tb_y86_fde_core: directed bench for y86_fde_core. A behavioural ISA model
// (length table, signed-overflow arithmetic, architectural register array)
// predicts every output; a negedge process compares DUT against it, and the
// directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_y86_fde_core;

  localparam int unsigned IMEM = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  pc;
  logic [79:0]  inst;
  logic [63:0]  valM;
  logic [3:0]   icode, ifun, rA, rB;
  logic [63:0]  valC, valP, valA, valB, valE;
  logic         cnd, zf, sf, of, instr_valid, imem_error, halt;
  logic [1:0]   stat;
  logic [959:0] regs_flat;

  always #5 clk = ~clk;

  y86_fde_core #(.IMEM_SIZE(IMEM)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .valM(valM),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .valA(valA), .valB(valB), .valE(valE), .cnd(cnd), .zf(zf), .sf(sf), .of(of),
    .instr_valid(instr_valid), .imem_error(imem_error), .halt(halt),
    .stat(stat), .regs_flat(regs_flat)
  );

  int checks   = 0;
  int failures = 0;
  logic chk_on = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------ ISA model
  logic [63:0] m_reg [15];
  logic        m_zf, m_sf, m_of;
  int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};

  int          tab_len, e_len;
  logic [3:0]  e_ic, e_fn, e_rA, e_rB, sA, sB, e_dstE, e_dstM;
  logic [63:0] e_valC, e_valP, e_valA, e_valB, e_valE;
  logic        e_valid, e_imem, e_halt, e_cnd, e_ovf, lt;
  logic [1:0]  e_stat;
  logic [64:0] wide;

  always_comb begin
    e_ic    = inst[7:4];
    e_fn    = inst[3:0];
    tab_len = len_tab[e_ic];
    case (e_ic)
      4'h2, 4'h7: e_valid = (e_fn <= 4'd6);
      4'h6:       e_valid = (e_fn <= 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF: e_valid = 1'b0;
      default:    e_valid = (e_fn == 4'd0);
    endcase
    e_len  = e_valid ? tab_len : 1;
    e_rA   = (tab_len == 2 || tab_len == 10) ? inst[15:12] : 4'hF;
    e_rB   = (tab_len == 2 || tab_len == 10) ? inst[11:8]  : 4'hF;
    e_valC = (tab_len == 10) ? inst[79:16] : (tab_len == 9) ? inst[71:8] : 64'd0;
    e_valP = pc + 64'(e_len);
    e_imem = ((65'(pc) + 65'(e_len)) > 65'(IMEM));
    e_halt = (e_ic == 4'h0);
    e_stat = e_imem ? 2'd3 : (!e_valid ? 2'd0 : (e_halt ? 2'd2 : 2'd1));
    sA = 4'hF;
    sB = 4'hF;
    if (e_ic == 4'h2 || e_ic == 4'h4 || e_ic == 4'h6 || e_ic == 4'hA) sA = e_rA;
    if (e_ic == 4'h9 || e_ic == 4'hB) sA = 4'h4;
    if (e_ic == 4'h4 || e_ic == 4'h5 || e_ic == 4'h6) sB = e_rB;
    if (e_ic == 4'h8 || e_ic == 4'h9 || e_ic == 4'hA || e_ic == 4'hB) sB = 4'h4;
    e_valA = (sA == 4'hF) ? 64'd0 : m_reg[sA];
    e_valB = (sB == 4'hF) ? 64'd0 : m_reg[sB];
    e_ovf  = 1'b0;
    wide   = 65'd0;
    case (e_ic)
      4'h2: e_valE = e_valA;
      4'h3: e_valE = e_valC;
      4'h4, 4'h5: e_valE = e_valB + e_valC;
      4'h6: begin
        case (e_fn)
          4'd0: begin wide = {e_valB[63], e_valB} + {e_valA[63], e_valA}; e_valE = wide[63:0]; e_ovf = wide[64] ^ wide[63]; end
          4'd1: begin wide = {e_valB[63], e_valB} - {e_valA[63], e_valA}; e_valE = wide[63:0]; e_ovf = wide[64] ^ wide[63]; end
          4'd2: e_valE = e_valB & e_valA;
          4'd3: e_valE = e_valB ^ e_valA;
          default: e_valE = 64'd0;
        endcase
      end
      4'h8, 4'hA: e_valE = e_valB - 64'd8;
      4'h9, 4'hB: e_valE = e_valB + 64'd8;
      default: e_valE = 64'd0;
    endcase
    lt = (m_sf != m_of);
    e_cnd = 1'b0;
    if (e_ic == 4'h2 || e_ic == 4'h7) begin
      case (e_fn)
        4'd0: e_cnd = 1'b1;
        4'd1: e_cnd = lt || m_zf;
        4'd2: e_cnd = lt;
        4'd3: e_cnd = m_zf;
        4'd4: e_cnd = !m_zf;
        4'd5: e_cnd = !lt;
        4'd6: e_cnd = !lt && !m_zf;
        default: e_cnd = 1'b0;
      endcase
    end
    e_dstE = 4'hF;
    e_dstM = 4'hF;
    if (e_ic == 4'h3 || e_ic == 4'h6 || (e_ic == 4'h2 && e_cnd)) e_dstE = e_rB;
    if (e_ic == 4'h8 || e_ic == 4'h9 || e_ic == 4'hA || e_ic == 4'hB) e_dstE = 4'h4;
    if (e_ic == 4'h5 || e_ic == 4'hB) e_dstM = e_rA;
  end

  // Architectural state update of the model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) m_reg[i] <= 64'd0;
      m_zf <= 1'b1;
      m_sf <= 1'b0;
      m_of <= 1'b0;
    end else if (e_stat == 2'd1) begin
      for (int i = 0; i < 15; i++) begin
        if (e_dstM == 4'(i)) m_reg[i] <= valM;
        else if (e_dstE == 4'(i)) m_reg[i] <= e_valE;
      end
      if (e_ic == 4'h6 && e_valid) begin
        m_zf <= (e_valE == 64'd0);
        m_sf <= e_valE[63];
        m_of <= e_ovf;
      end
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("icode", {60'd0, icode}, {60'd0, e_ic});
      cmp("ifun", {60'd0, ifun}, {60'd0, e_fn});
      cmp("rA", {60'd0, rA}, {60'd0, e_rA});
      cmp("rB", {60'd0, rB}, {60'd0, e_rB});
      cmp("valC", valC, e_valC);
      cmp("valP", valP, e_valP);
      cmp("valA", valA, e_valA);
      cmp("valB", valB, e_valB);
      cmp("valE", valE, e_valE);
      cmp("cnd", {63'd0, cnd}, {63'd0, e_cnd});
      cmp("flags", {61'd0, zf, sf, of}, {61'd0, m_zf, m_sf, m_of});
      cmp("instr_valid", {63'd0, instr_valid}, {63'd0, e_valid});
      cmp("imem_error", {63'd0, imem_error}, {63'd0, e_imem});
      cmp("halt", {63'd0, halt}, {63'd0, e_halt});
      cmp("stat", {62'd0, stat}, {62'd0, e_stat});
      for (int i = 0; i < 15; i++) cmp($sformatf("reg%0d", i), regs_flat[64*i +: 64], m_reg[i]);
    end
  end

  // ------------------------------------------------------------ stimulus
  function automatic logic [79:0] ins10(input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] c);
    return {c, b1, b0};
  endfunction
  function automatic logic [79:0] ins9(input logic [7:0] b0, input logic [63:0] c);
    return {8'h00, c, b0};
  endfunction
  function automatic logic [79:0] ins2(input logic [7:0] b0, input logic [7:0] b1);
    return {64'd0, b1, b0};
  endfunction

  task automatic drive(input logic [63:0] p, input logic [79:0] in, input logic [63:0] vm);
    pc = p; inst = in; valM = vm;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] p;

  initial begin
    rst_n = 1'b1;
    pc = 64'd0; inst = ins2(8'h10, 8'h00); valM = 64'd0;
    #1 rst_n = 1'b0;
    #2;
    cmp("rst_regs_lo", regs_flat[63:0], 64'd0);
    cmp("rst_flags", {61'd0, zf, sf, of}, 64'd4);
    #10 rst_n = 1'b1;
    tick;
    chk_on = 1'b1;

    // irmovq $0x10,%rax
    p = 64'd0;
    drive(p, ins10(8'h30, 8'hF0, 64'h10), 64'd0);
    cmp("t1_valP", valP, 64'd10);
    cmp("t1_valC", valC, 64'h10);
    cmp("t1_valE", valE, 64'h10);
    cmp("t1_stat", {62'd0, stat}, 64'd1);
    tick;
    cmp("t1_rax", regs_flat[63:0], 64'h10);
    p = 64'd10;

    // rax=5, rbx=5, subq %rax,%rbx, jne
    drive(p, ins10(8'h30, 8'hF0, 64'd5), 64'd0); tick; p += 64'd10;
    drive(p, ins10(8'h30, 8'hF3, 64'd5), 64'd0); tick; p += 64'd10;
    drive(p, ins2(8'h61, 8'h03), 64'd0);
    cmp("sub_valE", valE, 64'd0);
    tick; p += 64'd2;
    cmp("sub_zf", {63'd0, zf}, 64'd1);
    drive(p, ins9(8'h74, 64'h40), 64'd0);
    cmp("jne_cnd", {63'd0, cnd}, 64'd0);
    cmp("jne_valP", valP, 64'd41);
    tick; p += 64'd9;

    // signed overflow on addq, then cmovl / cmovge
    drive(p, ins10(8'h30, 8'hF0, 64'h7FFF_FFFF_FFFF_FFFF), 64'd0); tick; p += 64'd10;
    drive(p, ins2(8'h60, 8'h00), 64'd0);
    cmp("add_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick; p += 64'd2;
    cmp("add_flags", {61'd0, zf, sf, of}, 64'd3);
    drive(p, ins2(8'h22, 8'h01), 64'd0);
    cmp("cmovl_cnd", {63'd0, cnd}, 64'd0);
    tick; p += 64'd2;
    cmp("cmovl_rcx", regs_flat[127:64], 64'd0);
    drive(p, ins2(8'h25, 8'h01), 64'd0); tick; p += 64'd2;

    // push/pop
    drive(p, ins10(8'h30, 8'hF4, 64'h100), 64'd0); tick; p += 64'd10;
    drive(p, ins10(8'h30, 8'hF3, 64'h77), 64'd0); tick; p += 64'd10;
    drive(p, ins2(8'hA0, 8'h3F), 64'd0);
    cmp("push_valA", valA, 64'h77);
    cmp("push_valE", valE, 64'hF8);
    tick; p += 64'd2;
    cmp("push_rsp", regs_flat[4*64 +: 64], 64'hF8);
    drive(p, ins2(8'hB0, 8'h4F), 64'h55);
    tick; p += 64'd2;
    cmp("pop_rsp", regs_flat[4*64 +: 64], 64'h55);

    // other legal instructions, checked against the model
    drive(p, ins2(8'h62, 8'h03), 64'd0); tick; p += 64'd2;
    drive(p, ins2(8'h63, 8'h33), 64'd0); tick; p += 64'd2;
    drive(p, ins10(8'h40, 8'h04, 64'h20), 64'd0); tick; p += 64'd10;
    drive(p, ins10(8'h50, 8'h6F, 64'h30), 64'hABCD); tick; p += 64'd10;
    drive(p, ins9(8'h80, 64'h200), 64'd0); tick; p = 64'h200;
    drive(p, ins2(8'h90, 8'h00), 64'h1234); tick; p += 64'd1;
    drive(p, ins2(8'h20, 8'h16), 64'd0); tick; p += 64'd2;
    drive(p, ins2(8'h10, 8'h00), 64'd0); tick; p += 64'd1;
    drive(p, ins9(8'h70, 64'h80), 64'd0); tick; p = 64'h80;

    // illegal / halt / address error / boundaries
    drive(p, ins2(8'hC0, 8'h00), 64'd0);
    cmp("ill_valid", {63'd0, instr_valid}, 64'd0);
    cmp("ill_stat", {62'd0, stat}, 64'd0);
    tick;
    drive(p, ins2(8'h27, 8'h01), 64'd0); tick;
    drive(p, ins2(8'h64, 8'h00), 64'd0); tick;
    drive(p, ins2(8'h00, 8'h00), 64'd0);
    cmp("halt_halt", {63'd0, halt}, 64'd1);
    cmp("halt_stat", {62'd0, stat}, 64'd2);
    tick;
    drive(64'd1022, ins10(8'h30, 8'hF0, 64'h99), 64'd0);
    cmp("adr_imem", {63'd0, imem_error}, 64'd1);
    cmp("adr_stat", {62'd0, stat}, 64'd3);
    tick;
    drive(64'd1014, ins10(8'h30, 8'hF1, 64'h99), 64'd0); tick;
    drive(64'hFFFF_FFFF_FFFF_FFFF, ins2(8'h10, 8'h00), 64'd0); tick;

    // asynchronous reset between edges
    drive(64'd0, ins2(8'h10, 8'h00), 64'd0);
    tick;
    #1 rst_n = 1'b0;
    #1;
    cmp("arst_rax", regs_flat[63:0], 64'd0);
    cmp("arst_rsp", regs_flat[4*64 +: 64], 64'd0);
    cmp("arst_zf", {63'd0, zf}, 64'd1);
    #1 rst_n = 1'b1;
    tick;
    drive(64'd0, ins10(8'h30, 8'hF2, 64'h1), 64'd0); tick;
    drive(64'd10, ins2(8'h61, 8'h22), 64'd0); tick;
    tick;

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_fde_core.md
Name: y86_fde_core

Overview:
- Combined fetch, decode/writeback and execute stages of a single-cycle (SEQ) Y86-64 processor.
- Fetch is combinational: it decodes the instruction bytes at the current PC and produces valP.
- Decode reads the 15-entry register file. Execute computes valE and cnd from the condition codes (CC).
- At each rising clock edge the block writes back valE/valM and updates CC. The PC register, data memory and PC-select logic sit outside the block.

Parameters:
- IMEM_SIZE, 1024, instruction memory size in bytes. Any access beyond it raises imem_error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc  in  64  address of the current instruction
- inst  in  80  10-byte instruction window at pc; byte k = inst[8k+7:8k], little-endian
- valM  in  64  data-memory read result, used for writeback
- icode, ifun  out  4 each  byte0[7:4], byte0[3:0]
- rA, rB  out  4 each  byte1[7:4], byte1[3:0]; 4'hF when the instruction has no register byte
- valC  out  64  constant field
- valP  out  64  pc + instruction length
- valA, valB  out  64  register operands
- valE  out  64  ALU result
- cnd  out  1  branch/move condition
- zf, sf, of  out  1 each  condition-code flags
- instr_valid  out  1  icode/ifun legal
- imem_error  out  1  pc + length > IMEM_SIZE
- halt  out  1  icode == 0
- stat  out  2  1=AOK, 2=HLT, 3=ADR (imem_error), 4 is not representable, so INS is encoded as 0 (invalid instruction)
- regs_flat  out  960  register i at [64i+63:64i]: rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8..r14

Behaviour:

Instruction lengths (by icode):
- 0 halt, 1 nop, 9 ret: 1 byte
- 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq: 2 bytes
- 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes
- 7 jXX, 8 call: 9 bytes

Field extraction:
- valC = bytes 2..9 for icodes 3, 4, 5; bytes 1..8 for icodes 7, 8; 0 otherwise.

Validity:
- Legal ifun: 0–3 for OPq; 0–6 for icodes 2 and 7; 0 for all other icodes. icode > B is illegal.
- On an illegal instruction, valP = pc + 1.

Status priority:
- stat = ADR if imem_error, else INS if !instr_valid, else HLT if halt, else AOK.

Register reads:
- srcA = rA for icodes 2, 4, 6, A; rsp for 9, B; none otherwise.
- srcB = rB for icodes 4, 5, 6; rsp for 8, 9, A, B; none otherwise.
- Reading "none" (4'hF) yields 0.

valE:
- 2: valA
- 3: valC
- 4, 5: valB + valC
- 6: valB op valA, with ifun 0 add, 1 sub (valB − valA), 2 and, 3 xor
- 8, A: valB − 8
- 9, B: valB + 8
- else: 0
- All arithmetic is 64-bit wrap-around.

Condition codes:
- Updated at the clock edge only for valid OPq while stat == AOK.
- ZF = (valE == 0); SF = valE[63].
- OF for add: operands have the same sign and the result sign differs.
- OF for sub: valB and valA signs differ and the result sign differs from valB.
- OF = 0 for and/xor.

cnd (combinational, only for icodes 2 and 7; otherwise 0):
- ifun 0: 1
- ifun 1 (le): (SF^OF) | ZF
- ifun 2 (l): SF^OF
- ifun 3 (e): ZF
- ifun 4 (ne): ~ZF
- ifun 5 (ge): ~(SF^OF)
- ifun 6 (g): ~(SF^OF) & ~ZF

Writeback at rising clk, only when stat == AOK:
- dstE = rB for icodes 3 and 6, and for icode 2 when cnd; rsp for 8, 9, A, B.
- dstM = rA for icodes 5 and B.
- When dstE == dstM, the valM write wins (popq %rsp loads the popped value).

Reset:
- rst_n low clears all registers to 0 and sets ZF=1, SF=0, OF=0 immediately, independent of clk.
- Combinational outputs follow their inputs during reset.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ
  - ALU function codes, condition function codes
  - RRSP = 4'h4, RNONE = 4'hF
  - stat codes
- One natural sub-module: y86_alu (64-bit add/sub/and/xor with ZF/SF/OF generation).

Test Plan:
- irmovq $0x10,%rax (30 F0 10 00..) at pc=0 → valP=10, valC=0x10, valE=0x10; after the edge rax=0x10; stat=AOK.
- rax=5, rbx=5, subq %rax,%rbx (61 03) → valE=0, ZF=1 after the edge. A following jne (74, dest 0x40) → cnd=0, valP=pc+9.
- rax=0x7FFF_FFFF_FFFF_FFFF, addq %rax,%rax → valE=0xFFFF_FFFF_FFFF_FFFE, OF=1, SF=1, ZF=0. Then cmovl → cnd=0 and no register write.
- rsp=0x100, pushq %rbx (A0 3F) → valA=rbx, valE=0xF8, rsp=0xF8 after the edge. Then popq %rsp with valM=0x55 → rsp=0x55.
- Illegal byte 0xC0 → instr_valid=0, stat=INS, no writes. Byte 0x00 → halt=1, stat=HLT. pc=IMEM_SIZE−2 with irmovq → imem_error=1, stat=ADR.
- rst_n asserted mid-run between edges → registers read 0 and ZF=1 without a clock edge.
